// File: rtl/decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl
//
// Scan controller that drives the select/enable inputs of a 3-to-8 decoder.
// It walks the lines enabled in `mask`, holding each one for a programmable
// dwell time. A one-cycle blanking gap plus a one-cycle search gap keep `en`
// low between lines, so no two decoder outputs are high in consecutive cycles.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   start     : begin a scan (accepted only while idle, and only without stop)
//   stop      : abort the scan from any busy state (no done pulse)
//   one_shot  : scan mode captured on an accepted start (1 = single pass)
//   mask      : line-enable bits, read live whenever a new line is searched
//   dwell     : active cycles per line, captured on entry to ACTIVE (0 -> 1)
//   sel       : decoder line index, changes only when en is about to rise
//   en        : decoder enable
//   busy      : high whenever the controller is not idle
//   done      : one-cycle pulse when a scan runs out of lines
// -----------------------------------------------------------------------------
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               one_shot,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        ACTIVE = 2'd2,
        BLANK  = 2'd3
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic               mode;   // 1 = single pass, 0 = continuous
    logic               first;  // next search is the first of this scan
    logic [3:0]         hit;    // {found, index}

    // A dwell of zero behaves like a dwell of one.
    function automatic logic [DWELL_W-1:0] clamp_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    // Lowest-numbered enabled line at or after the search base. The base is 0
    // for the first line of a scan, otherwise the line after `cur`. Without
    // wrap the search ends at line 7; with wrap it covers all eight lines and
    // lands back on `cur` last, so a single-bit mask repeats its line.
    function automatic logic [3:0] find_line(
        input logic [7:0] m,
        input logic [2:0] cur,
        input logic       from_zero,
        input logic       wrap
    );
        logic [3:0] base;
        logic [3:0] idx;
        logic [3:0] res;
        logic       found;
        base  = from_zero ? 4'd0 : ({1'b0, cur} + 4'd1);
        res   = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = base + 4'(i);
            if (!found && (wrap || !idx[3]) && m[idx[2:0]]) begin
                found = 1'b1;
                res   = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

    assign hit = find_line(mask, sel, first, ~mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 3'd0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            mode  <= 1'b0;
            first <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop && state != IDLE) begin
                // Abort wins over every other transition.
                state <= IDLE;
                en    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            mode  <= one_shot;
                            first <= 1'b1;
                            busy  <= 1'b1;
                            state <= SEEK;
                        end
                    end
                    SEEK: begin
                        if (hit[3]) begin
                            sel   <= hit[2:0];
                            first <= 1'b0;
                            cnt   <= clamp_dwell(dwell);
                            en    <= 1'b1;
                            state <= ACTIVE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    ACTIVE: begin
                        if (cnt == DWELL_W'(1)) begin
                            en    <= 1'b0;
                            state <= BLANK;
                        end else begin
                            cnt <= cnt - DWELL_W'(1);
                        end
                    end
                    BLANK: begin
                        state <= SEEK;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_ctrl
//
// Bench for decoder_scan_ctrl. One-shot scans come from a vector table; each
// expected line (index and dwell) is queued when the scan is started and
// compared when the DUT finishes that en pulse. Continuous mode, wrap with a
// mid-scan mask clear, start/stop collision and asynchronous reset are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

    localparam int DWELL_W = 8;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               start    = 1'b0;
    logic               stop     = 1'b0;
    logic               one_shot = 1'b0;
    logic [7:0]         mask     = 8'h00;
    logic [DWELL_W-1:0] dwell    = '0;
    logic [2:0]         sel;
    logic               en;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]      mask;
        logic [7:0]      dwell;
        int              nlines;
        logic [7:0][2:0] sels;
        int              exp_done;  // edges from first SEEK to done
    } vec_t;

    typedef struct {
        logic [2:0] sel;
        int         len;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];
    exp_t e_mon;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .one_shot (one_shot),
        .mask     (mask),
        .dwell    (dwell),
        .sel      (sel),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulse monitor: measures each en pulse and the en-low gap before it.
    logic       mon_en    = 1'b0;
    logic       en_prev   = 1'b0;
    logic       have_prev = 1'b0;
    logic [2:0] cur_sel   = 3'd0;
    int         run       = 0;
    int         low       = 0;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            en_prev   = 1'b0;
            have_prev = 1'b0;
            run       = 0;
            low       = 0;
        end else begin
            if (en) begin
                if (!en_prev) begin
                    if (have_prev) check("gap between lines", low, 2);
                    run     = 1;
                    cur_sel = sel;
                end else begin
                    run++;
                    check("sel stable while en", sel, cur_sel);
                end
            end else begin
                if (en_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected en pulse", 1, 0);
                    end else begin
                        e_mon = sb.pop_front();
                        check("line sel", cur_sel, e_mon.sel);
                        check("line dwell", run, e_mon.len);
                    end
                    have_prev = 1'b1;
                    low       = 1;
                end else begin
                    low++;
                end
            end
            en_prev = en;
            if (!busy) have_prev = 1'b0;
        end
    end

    task automatic run_oneshot(input vec_t v);
        int cyc;
        for (int i = 0; i < v.nlines; i++)
            sb.push_back(exp_t'{sel: v.sels[i], len: (v.dwell == 0) ? 1 : int'(v.dwell)});
        mask     = v.mask;
        dwell    = v.dwell;
        one_shot = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after start", busy, 1);
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done latency", cyc, v.exp_done);
        check("busy at done", busy, 0);
        @(posedge clk); #1;
        check("done width", done, 0);
        check("lines outstanding", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        int cyc;

        vecs[0] = '{mask: 8'hA5, dwell: 8'd3, nlines: 4,
                    sels: {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2, 3'd0}, exp_done: 21};
        vecs[1] = '{mask: 8'h80, dwell: 8'd1, nlines: 1,
                    sels: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}, exp_done: 4};
        vecs[2] = '{mask: 8'hFF, dwell: 8'd0, nlines: 8,
                    sels: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, exp_done: 25};
        vecs[3] = '{mask: 8'h18, dwell: 8'd5, nlines: 2,
                    sels: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3}, exp_done: 15};
        vecs[4] = '{mask: 8'h00, dwell: 8'd3, nlines: 0,
                    sels: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, exp_done: 1};

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {sel, en, busy, done}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle outputs", {sel, en, busy, done}, 0);
        end

        // One-shot table, including the empty mask
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) run_oneshot(vecs[i]);

        // start and stop together while idle
        start = 1'b1;
        stop  = 1'b1;
        mask  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("start+stop idle", {en, busy, done}, 0);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Continuous single line, dwell 0: en = 1,0,0 repeating, then stop
        mon_en   = 1'b0;
        mask     = 8'h01;
        dwell    = '0;
        one_shot = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            check("continuous en pattern", en, (j % 3 == 0) ? 1 : 0);
            check("continuous sel", sel, 0);
            check("continuous no done", done, 0);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("stop en/busy/done", {en, busy, done}, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("after stop", {en, busy, done}, 0);
        end

        // Continuous wrap 1,7,1,7 with mask cleared during the second line 7
        mon_en = 1'b1;
        sb.push_back(exp_t'{sel: 3'd1, len: 2});
        sb.push_back(exp_t'{sel: 3'd7, len: 2});
        sb.push_back(exp_t'{sel: 3'd1, len: 2});
        sb.push_back(exp_t'{sel: 3'd7, len: 2});
        mask     = 8'h82;
        dwell    = 8'd2;
        one_shot = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (13) begin
            @(posedge clk); #1;
        end
        check("wrap line 7 active en", en, 1);
        check("wrap line 7 active sel", sel, 7);
        mask = 8'h00;
        cyc  = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mask clear done latency", cyc, 4);
        check("mask clear busy", busy, 0);
        @(posedge clk); #1;
        check("wrap lines outstanding", sb.size(), 0);
        sb.delete();

        // Asynchronous reset in the middle of line 2
        mon_en   = 1'b0;
        mask     = 8'hA5;
        dwell    = 8'd4;
        one_shot = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre-reset en", en, 1);
        check("pre-reset sel", sel, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset en", en, 0);
        check("async reset sel", sel, 0);
        check("async reset busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle after reset", {sel, en, busy, done}, 0);
        end
        mon_en = 1'b1;
        run_oneshot(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
